// File: rtl/iir_biquad_cascade_pkg.sv
// Shared types and helpers for the time-multiplexed biquad cascade.
//   coeff_idx_e : coefficient slot / MAC step index (b0,b1,b2,a1,a2)
//   state_e     : sequencer states
//   sat_shift   : arithmetic right shift (floor) followed by clamp to a dw-bit signed range
package iir_pkg;

    localparam int unsigned Q_INT_BITS = 2;   // coefficients are Q2.(CW-2)
    localparam int unsigned NCOEF      = 5;
    localparam int unsigned NSTATE     = 4;

    // Slots of the per-(ch,sec) state vector
    localparam int unsigned ST_X1 = 0;
    localparam int unsigned ST_X2 = 1;
    localparam int unsigned ST_Y1 = 2;
    localparam int unsigned ST_Y2 = 3;

    typedef enum logic [2:0] {
        C_B0 = 3'd0,
        C_B1 = 3'd1,
        C_B2 = 3'd2,
        C_A1 = 3'd3,
        C_A2 = 3'd4
    } coeff_idx_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_WB,
        S_DONE
    } state_e;

    // Result is 64-bit; callers keep the low dw bits (dw <= 32).
    function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                     input int unsigned shift,
                                                     input int unsigned dw);
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh = acc >>> shift;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (sh > hi) begin
            sh = hi;
        end else if (sh < lo) begin
            sh = lo;
        end
        return sh;
    endfunction

endpackage

// File: rtl/iir_biquad_cascade_if.sv
// Sample stream + coefficient/clear control bundle of the biquad cascade.
//   master : frame source / configuration side
//   slave  : the filter
//   in_valid/in_ready/in_data, out_valid/out_data, cfg_we/cfg_ready/cfg_sec/cfg_idx/cfg_data, clear
interface iir_biquad_cascade_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned DW  = 16,
    parameter int unsigned CW  = 24
);
    logic                in_valid;
    logic                in_ready;
    logic [NCH*DW-1:0]   in_data;
    logic                out_valid;
    logic [NCH*DW-1:0]   out_data;
    logic                cfg_we;
    logic                cfg_ready;
    logic [1:0]          cfg_sec;
    logic [2:0]          cfg_idx;
    logic [CW-1:0]       cfg_data;
    logic                clear;

    modport master (
        output in_valid, in_data, cfg_we, cfg_sec, cfg_idx, cfg_data, clear,
        input  in_ready, out_valid, out_data, cfg_ready
    );

    modport slave (
        input  in_valid, in_data, cfg_we, cfg_sec, cfg_idx, cfg_data, clear,
        output in_ready, out_valid, out_data, cfg_ready
    );
endinterface

// File: rtl/iir_biquad_cascade_mac.sv
// Single shared multiply-accumulate for the biquad cascade.
//   clk, reset : clock, synchronous active-high reset
//   en_i       : accumulate this cycle
//   clr_i      : start a new sum (first term of a section)
//   sub_i      : subtract the product instead of adding (feedback terms)
//   a_i, b_i   : signed sample (DW) and coefficient (CW)
//   acc_o      : registered AW-bit accumulator
module iir_mac #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 24,
    parameter int unsigned AW = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 sub_i,
    input  logic signed [DW-1:0] a_i,
    input  logic signed [CW-1:0] b_i,
    output logic signed [AW-1:0] acc_o
);
    logic signed [DW+CW-1:0] prod;
    logic signed [AW-1:0]    term;
    logic signed [AW-1:0]    base;
    logic signed [AW-1:0]    acc_q;

    // Negation happens after sign extension so -(-2^(DW+CW-2)) cannot overflow.
    always_comb begin
        prod = a_i * b_i;
        term = sub_i ? -AW'(prod) : AW'(prod);
        base = clr_i ? '0 : acc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= base + term;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/iir_biquad_cascade.sv
// NCH channels x NSEC cascaded direct-form-I biquads on one shared multiplier.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of iir_biquad_cascade_if (frame in/out, coefficient writes, clear)
// Each section costs 5 MAC cycles + 1 writeback; a frame takes 6*NCH*NSEC+2 cycles.
module iir_biquad_cascade
    import iir_pkg::*;
#(
    parameter int unsigned NCH  = 2,
    parameter int unsigned NSEC = 2,
    parameter int unsigned DW   = 16,
    parameter int unsigned CW   = 24,
    parameter int unsigned AW   = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    iir_biquad_cascade_if.slave   bus
);
    localparam int unsigned CHW  = (NCH  > 1) ? $clog2(NCH)  : 1;
    localparam int unsigned SECW = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int unsigned FRAC = CW - Q_INT_BITS;
    localparam logic signed [CW-1:0] COEF_ONE = CW'(64'd1 << FRAC);

    state_e                state_q;
    coeff_idx_e            k_q;
    logic [CHW-1:0]        ch_q;
    logic [SECW-1:0]       sec_q;
    logic [NCH*DW-1:0]     frame_q;
    logic [NCH*DW-1:0]     res_q;
    logic [NCH*DW-1:0]     out_data_q;
    logic signed [DW-1:0]  link_q;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic                  clr_pend_q;
    logic signed [CW-1:0]  coef_q [NSEC][NCOEF];
    logic signed [DW-1:0]  st_q   [NCH][NSEC][NSTATE];

    logic signed [DW-1:0]  x0;
    logic signed [DW-1:0]  mul_a;
    logic signed [CW-1:0]  mul_b;
    logic                  mul_sub;
    logic signed [AW-1:0]  acc;
    logic signed [DW-1:0]  yq;
    logic [1:0]            cfg_sec_m;
    logic                  cfg_take;
    logic                  accept;
    logic                  wipe;

    // Section 0 reads the latched input sample; later sections chain from the previous writeback.
    assign x0 = (sec_q == '0) ? frame_q[ch_q*DW +: DW] : link_q;

    always_comb begin
        mul_a   = x0;
        mul_b   = coef_q[sec_q][C_B0];
        mul_sub = 1'b0;
        case (k_q)
            C_B1: begin mul_a = st_q[ch_q][sec_q][ST_X1]; mul_b = coef_q[sec_q][C_B1]; end
            C_B2: begin mul_a = st_q[ch_q][sec_q][ST_X2]; mul_b = coef_q[sec_q][C_B2]; end
            C_A1: begin mul_a = st_q[ch_q][sec_q][ST_Y1]; mul_b = coef_q[sec_q][C_A1]; mul_sub = 1'b1; end
            C_A2: begin mul_a = st_q[ch_q][sec_q][ST_Y2]; mul_b = coef_q[sec_q][C_A2]; mul_sub = 1'b1; end
            default: ;
        endcase
    end

    iir_mac #(.DW(DW), .CW(CW), .AW(AW)) u_mac (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q == S_MAC),
        .clr_i (k_q == C_B0),
        .sub_i (mul_sub),
        .a_i   (mul_a),
        .b_i   (mul_b),
        .acc_o (acc)
    );

    assign yq        = DW'(sat_shift(64'(acc), FRAC, DW));
    assign cfg_sec_m = bus.cfg_sec & 2'((1 << SECW) - 1);
    assign cfg_take  = (state_q == S_IDLE) && bus.cfg_we && (bus.cfg_idx <= C_A2)
                       && (32'(cfg_sec_m) < NSEC);
    assign accept    = (state_q == S_IDLE) && bus.in_valid;
    // A clear seen while busy is applied on the DONE edge, i.e. when IDLE is re-entered.
    assign wipe      = ((state_q == S_IDLE) && bus.clear)
                       || ((state_q == S_DONE) && (clr_pend_q || bus.clear));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            k_q         <= C_B0;
            ch_q        <= '0;
            sec_q       <= '0;
            frame_q     <= '0;
            res_q       <= '0;
            out_data_q  <= '0;
            link_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            for (int unsigned s = 0; s < NSEC; s++) begin
                for (int unsigned c = 0; c < NCOEF; c++) begin
                    coef_q[s][c] <= (c == 0) ? COEF_ONE : '0;
                end
            end
            for (int unsigned c = 0; c < NCH; c++) begin
                for (int unsigned s = 0; s < NSEC; s++) begin
                    for (int unsigned i = 0; i < NSTATE; i++) begin
                        st_q[c][s][i] <= '0;
                    end
                end
            end
        end else begin
            out_valid_q <= 1'b0;

            if (cfg_take) begin
                coef_q[SECW'(cfg_sec_m)][bus.cfg_idx] <= bus.cfg_data;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        frame_q    <= bus.in_data;
                        ch_q       <= '0;
                        sec_q      <= '0;
                        k_q        <= C_B0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (bus.clear) clr_pend_q <= 1'b1;
                    if (k_q == C_A2) begin
                        k_q     <= C_B0;
                        state_q <= S_WB;
                    end else begin
                        k_q <= coeff_idx_e'(k_q + 3'd1);
                    end
                end
                S_WB: begin
                    if (bus.clear) clr_pend_q <= 1'b1;
                    st_q[ch_q][sec_q][ST_X2] <= st_q[ch_q][sec_q][ST_X1];
                    st_q[ch_q][sec_q][ST_X1] <= x0;
                    st_q[ch_q][sec_q][ST_Y2] <= st_q[ch_q][sec_q][ST_Y1];
                    st_q[ch_q][sec_q][ST_Y1] <= yq;
                    link_q <= yq;
                    k_q    <= C_B0;
                    if (sec_q == SECW'(NSEC - 1)) begin
                        res_q[ch_q*DW +: DW] <= yq;
                        sec_q <= '0;
                        if (ch_q == CHW'(NCH - 1)) begin
                            state_q <= S_DONE;
                        end else begin
                            ch_q    <= ch_q + CHW'(1);
                            state_q <= S_MAC;
                        end
                    end else begin
                        sec_q   <= sec_q + SECW'(1);
                        state_q <= S_MAC;
                    end
                end
                S_DONE: begin
                    out_data_q  <= res_q;
                    out_valid_q <= 1'b1;
                    in_ready_q  <= 1'b1;
                    clr_pend_q  <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            if (wipe) begin
                for (int unsigned c = 0; c < NCH; c++) begin
                    for (int unsigned s = 0; s < NSEC; s++) begin
                        for (int unsigned i = 0; i < NSTATE; i++) begin
                            st_q[c][s][i] <= '0;
                        end
                    end
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.cfg_ready = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Scoreboard bench for iir_biquad_cascade (NCH=2, NSEC=2, DW=16, CW=24, AW=48).
// A behavioural cascade model predicts each accepted frame; predictions are queued at accept
// time and compared when out_valid pulses.
module tb_iir_biquad_cascade;
    localparam int unsigned NCH  = 2;
    localparam int unsigned NSEC = 2;
    localparam int unsigned DW   = 16;
    localparam int unsigned CW   = 24;
    localparam int unsigned AW   = 48;
    localparam int          LAT  = 6 * NCH * NSEC + 1;

    logic clk;
    logic reset;
    int   cyc;
    int   n_cmp;
    int   n_err;

    iir_biquad_cascade_if #(.NCH(NCH), .DW(DW), .CW(CW)) bus ();

    iir_biquad_cascade #(.NCH(NCH), .NSEC(NSEC), .DW(DW), .CW(CW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    longint mcoef [NSEC][5];
    longint mst   [NCH][NSEC][4];
    bit     mpend;
    logic [NCH*DW-1:0] exp_q [$];
    int     acc_cyc, prev_acc, n_acc, n_ov;

    task automatic model_reset();
        for (int s = 0; s < NSEC; s++)
            for (int i = 0; i < 5; i++) mcoef[s][i] = (i == 0) ? (longint'(1) << (CW - 2)) : 0;
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NSEC; s++)
                for (int i = 0; i < 4; i++) mst[c][s][i] = 0;
        mpend = 0;
    endtask

    task automatic model_wipe();
        for (int c = 0; c < NCH; c++)
            for (int s = 0; s < NSEC; s++)
                for (int i = 0; i < 4; i++) mst[c][s][i] = 0;
    endtask

    task automatic model_frame(input logic [NCH*DW-1:0] din, output logic [NCH*DW-1:0] dout);
        longint x, acc, y;
        logic signed [DW-1:0] smp;
        dout = '0;
        for (int c = 0; c < NCH; c++) begin
            smp = din[c*DW +: DW];
            x = smp;
            for (int s = 0; s < NSEC; s++) begin
                acc = mcoef[s][0] * x + mcoef[s][1] * mst[c][s][0] + mcoef[s][2] * mst[c][s][1]
                    - mcoef[s][3] * mst[c][s][2] - mcoef[s][4] * mst[c][s][3];
                y = acc >>> (CW - 2);
                if (y > 32767) y = 32767;
                if (y < -32768) y = -32768;
                mst[c][s][1] = mst[c][s][0];
                mst[c][s][0] = x;
                mst[c][s][3] = mst[c][s][2];
                mst[c][s][2] = y;
                x = y;
            end
            dout[c*DW +: DW] = x[DW-1:0];
        end
    endtask

    // Monitor samples 2 time units after the falling edge: inputs driven at negedge are settled.
    initial begin
        logic [NCH*DW-1:0] e;
        logic signed [CW-1:0] cv;
        model_reset();
        acc_cyc = 0; prev_acc = 0; n_acc = 0; n_ov = 0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                model_reset();
                exp_q.delete();
            end else begin
                if (bus.out_valid) begin
                    n_ov++;
                    if (exp_q.size() == 0) begin
                        check("sb_unexpected_out", 64'(exp_q.size()), 64'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", 64'(bus.out_data), 64'(e));
                        check("latency", 64'(cyc - acc_cyc), 64'(LAT));
                    end
                    if (mpend) begin
                        model_wipe();
                        mpend = 0;
                    end
                end
                if (bus.clear) begin
                    if (bus.in_ready) model_wipe();
                    else mpend = 1;
                end
                if (bus.cfg_we && bus.cfg_ready && bus.cfg_idx < 3'd5) begin
                    cv = bus.cfg_data;
                    mcoef[int'(bus.cfg_sec) % NSEC][bus.cfg_idx] = cv;
                end
                if (bus.in_valid && bus.in_ready) begin
                    model_frame(bus.in_data, e);
                    exp_q.push_back(e);
                    prev_acc = acc_cyc;
                    acc_cyc  = cyc + 1;
                    n_acc++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(tag, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic send(input logic [NCH*DW-1:0] f);
        @(negedge clk);
        wait_ready("send_timeout");
        bus.in_valid = 1'b1;
        bus.in_data  = f;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] sec, input logic [2:0] idx, input logic [CW-1:0] d);
        @(negedge clk);
        wait_ready("cfg_timeout");
        bus.cfg_we = 1'b1; bus.cfg_sec = sec; bus.cfg_idx = idx; bus.cfg_data = d;
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int a0, ov0;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.cfg_we = 1'b0; bus.cfg_sec = '0;
        bus.cfg_idx = '0; bus.cfg_data = '0; bus.clear = 1'b0;
        n_cmp = 0; n_err = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_cfg_ready", 64'(bus.cfg_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));

        // identity after reset
        send({16'h1234, 16'h8000});
        drain();

        // gain 0.5 on section 0
        cfg(2'd0, 3'd0, 24'h200000);
        send({16'h7FFF, 16'h7FFF});
        send({16'h8000, 16'h8000});
        drain();

        // b0 just under 2.0 -> saturation both ways
        cfg(2'd0, 3'd0, 24'h7FFFFF);
        send({16'h7000, 16'h9000});
        drain();

        // one-pole recursion y = x + 0.5*y1
        cfg(2'd0, 3'd0, 24'h400000);
        cfg(2'd0, 3'd3, 24'hE00000);
        pulse_clear();
        send({16'h4000, 16'h4000});
        send('0);
        send('0);
        send('0);
        drain();
        // clear while busy: this frame still sees old state, the next one does not
        send('0);
        repeat (8) @(negedge clk);
        check("busy_in_ready", 64'(bus.in_ready), 64'(0));
        pulse_clear();
        drain();
        send('0);
        drain();

        // back to identity, then back-to-back handshake with a refused coefficient write
        cfg(2'd0, 3'd3, 24'h000000);
        @(negedge clk);
        a0 = n_acc;
        bus.in_valid = 1'b1;
        bus.in_data  = {16'h2222, 16'h1111};
        for (int i = 0; i < 52; i++) begin
            if (i == 5) begin
                bus.cfg_we = 1'b1; bus.cfg_sec = 2'd0; bus.cfg_idx = 3'd0; bus.cfg_data = 24'h100000;
            end
            if (i == 6) bus.cfg_we = 1'b0;
            if (i == 10) check("cfg_ready_busy", 64'(bus.cfg_ready), 64'(0));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("accept_count", 64'(n_acc - a0), 64'(2));
        check("accept_interval", 64'(acc_cyc - prev_acc), 64'(LAT + 1));
        drain();
        send({16'h0F0F, 16'hF0F0});
        drain();

        // reset mid-frame with a non-identity coefficient loaded
        cfg(2'd1, 3'd0, 24'h200000);
        send({16'h4444, 16'h5555});
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ov0 = n_ov;
        @(negedge clk);
        check("abort_out_data", 64'(bus.out_data), 64'(0));
        check("abort_in_ready", 64'(bus.in_ready), 64'(1));
        repeat (40) @(negedge clk);
        check("abort_no_out_valid", 64'(n_ov - ov0), 64'(0));
        send({16'h1234, 16'h5678});
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
